// File: rtl/rotary_pkg.sv
// Shared constants and types for the rotary encoder counter: step
// directions, quadrature phase encodings {a,b} and the per-tick transition
// classifier used by the decoder.
package rotary_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Quadrature phases as {a,b} after inversion; CW order is 00->10->11->01->00
    localparam logic [1:0] PH_00 = 2'b00;
    localparam logic [1:0] PH_10 = 2'b10;
    localparam logic [1:0] PH_11 = 2'b11;
    localparam logic [1:0] PH_01 = 2'b01;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        INC  = 2'd1,
        DEC  = 2'd2,
        ERR  = 2'd3
    } trans_t;

    // Classify the move from prev to cur: any single-bit move is either the
    // next CW phase (INC) or the previous one (DEC); a two-bit move is illegal.
    function automatic trans_t classify(input logic [1:0] prev, input logic [1:0] cur);
        trans_t res;
        if (prev == cur) begin
            res = NONE;
        end else if ((prev ^ cur) == 2'b11) begin
            res = ERR;
        end else begin
            case (prev)
                PH_00:   res = (cur == PH_10) ? INC : DEC;
                PH_10:   res = (cur == PH_11) ? INC : DEC;
                PH_11:   res = (cur == PH_01) ? INC : DEC;
                PH_01:   res = (cur == PH_00) ? INC : DEC;
                default: res = NONE;
            endcase
        end
        return res;
    endfunction

endpackage

// File: rtl/rotary_debounce.sv
// One encoder channel: inverts the negative-logic pin, synchronises it with
// two flops and accepts a new level only after it has been seen on
// DEBOUNCE_TICKS consecutive sample ticks.
module rotary_debounce #(
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic tick,
    input  logic pin_n,
    output logic level
);

    logic       sync_p0;
    logic       sync_p1;
    logic [3:0] stable_cnt;

    // Two-flop synchroniser on the inverted asynchronous pin
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= ~pin_n;
            sync_p1 <= sync_p0;
        end
    end

    // Tick-gated stable counter; the level moves once the difference persists
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            stable_cnt <= '0;
            level      <= 1'b0;
        end else if (tick) begin
            if (sync_p1 != level) begin
                if (stable_cnt == 4'(DEBOUNCE_TICKS - 1)) begin
                    level      <= sync_p1;
                    stable_cnt <= '0;
                end else begin
                    stable_cnt <= stable_cnt + 4'd1;
                end
            end else begin
                stable_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/rotary_counter_core.sv
// Rotary encoder up/down counter in the system clock domain. A sample tick
// paces debounce and quadrature decode; completed detents step a
// saturating or wrapping count, with a synchronous clamped load on top.
// Optional build macro ROTARY_ACCEL_EN: fast same-direction detents step by
// ACCEL_STEP instead of 1.
module rotary_counter_core
    import rotary_pkg::*;
#(
    parameter int WIDTH            = 10,
    parameter int MIN_VAL          = 0,
    parameter int MAX_VAL          = 1023,
    parameter int RESET_VAL        = 0,
    parameter int WRAP             = 0,
    parameter int TICK_DIV         = 8000,
    parameter int DEBOUNCE_TICKS   = 4,
    parameter int STEPS_PER_DETENT = 4,
    parameter int ACCEL_WINDOW     = 20,
    parameter int ACCEL_STEP       = 8
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             A_raw,
    input  logic             B_raw,
    input  logic             Load,
    input  logic [WIDTH-1:0] Load_value,
    output logic [WIDTH-1:0] Count,
    output logic             Step_valid,
    output logic             Step_dir,
    output logic             Quad_err,
    output logic             At_min,
    output logic             At_max
);

    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int ACC_W  = $clog2(STEPS_PER_DETENT) + 2;

    localparam logic signed [ACC_W-1:0] ACC_ONE  = ACC_W'(1);
    localparam logic signed [ACC_W-1:0] ACC_LIM  = ACC_W'(STEPS_PER_DETENT);
    localparam logic signed [ACC_W-1:0] ACC_NLIM = -ACC_LIM;

    if (TICK_DIV < 2 || DEBOUNCE_TICKS < 1 || DEBOUNCE_TICKS > 15 ||
        !(STEPS_PER_DETENT == 1 || STEPS_PER_DETENT == 2 || STEPS_PER_DETENT == 4) ||
        MIN_VAL >= MAX_VAL || RESET_VAL < MIN_VAL || RESET_VAL > MAX_VAL ||
        ACCEL_WINDOW < 1 || ACCEL_STEP < 1) begin : g_bad_cfg
        $error("rotary_counter_core: illegal parameter combination");
    end

    logic [TICK_W-1:0]       tick_cnt;
    logic                    tick;
    logic                    a_deb;
    logic                    b_deb;
    logic [1:0]              cur_ph;
    logic [1:0]              prev_ph;
    trans_t                  trans;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_next;
    logic                    step_up;
    logic                    step_dn;
    logic                    err;
    int                      inc;
    logic [WIDTH-1:0]        count_next;

    // Saturating/wrapping add of inc, compared at full int width
    function automatic logic [WIDTH-1:0] count_up(input logic [WIDTH-1:0] cur, input int amt);
        int sum;
        sum = int'(cur) + amt;
        if (sum > MAX_VAL) return (WRAP != 0) ? WIDTH'(MIN_VAL) : WIDTH'(MAX_VAL);
        return WIDTH'(sum);
    endfunction

    function automatic logic [WIDTH-1:0] count_down(input logic [WIDTH-1:0] cur, input int amt);
        int dif;
        dif = int'(cur) - amt;
        if (dif < MIN_VAL) return (WRAP != 0) ? WIDTH'(MAX_VAL) : WIDTH'(MIN_VAL);
        return WIDTH'(dif);
    endfunction

    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
        if (int'(v) < MIN_VAL) return WIDTH'(MIN_VAL);
        if (int'(v) > MAX_VAL) return WIDTH'(MAX_VAL);
        return v;
    endfunction

    assign tick = (tick_cnt == TICK_W'(TICK_DIV - 1));

    // Free-running sample-tick divider
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) tick_cnt <= '0;
        else          tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);
    end

    rotary_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_deb_a (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .tick    (tick),
        .pin_n   (A_raw),
        .level   (a_deb)
    );

    rotary_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_deb_b (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .tick    (tick),
        .pin_n   (B_raw),
        .level   (b_deb)
    );

    assign cur_ph = {a_deb, b_deb};
    assign trans  = classify(prev_ph, cur_ph);

    // Detent accumulation: a completed detent produces a step and clears at once
    always_comb begin
        acc_next = acc_q;
        step_up  = 1'b0;
        step_dn  = 1'b0;
        err      = 1'b0;
        if (tick) begin
            case (trans)
                INC:     acc_next = acc_q + ACC_ONE;
                DEC:     acc_next = acc_q - ACC_ONE;
                ERR: begin
                    acc_next = '0;
                    err      = 1'b1;
                end
                default: acc_next = acc_q;
            endcase
        end
        if (acc_next == ACC_LIM) begin
            step_up  = 1'b1;
            acc_next = '0;
        end else if (acc_next == ACC_NLIM) begin
            step_dn  = 1'b1;
            acc_next = '0;
        end
    end

    // Decode state advances only on the sample tick
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            prev_ph <= PH_00;
            acc_q   <= '0;
        end else if (tick) begin
            prev_ph <= cur_ph;
            acc_q   <= acc_next;
        end
    end

`ifdef ROTARY_ACCEL_EN
    localparam int GAP_W = $clog2(ACCEL_WINDOW + 1);

    logic [GAP_W-1:0] gap_q;
    logic             same_dir;
    logic             accel;

    assign same_dir = step_up ? (Step_dir == DIR_UP) : (Step_dir == DIR_DOWN);
    assign accel    = (int'(gap_q) < ACCEL_WINDOW) && same_dir;
    assign inc      = accel ? ACCEL_STEP : 1;

    // Ticks since the last detent, saturating so an idle encoder reads as slow
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)                                 gap_q <= GAP_W'(ACCEL_WINDOW);
        else if (step_up || step_dn)                  gap_q <= '0;
        else if (tick && int'(gap_q) < ACCEL_WINDOW)  gap_q <= gap_q + GAP_W'(1);
    end
`else
    assign inc = 1;
`endif

    // Next count: load wins over any step completing in the same cycle
    always_comb begin
        count_next = Count;
        if (Load)         count_next = clamp_load(Load_value);
        else if (step_up) count_next = count_up(Count, inc);
        else if (step_dn) count_next = count_down(Count, inc);
    end

    // Registered count and status outputs
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Count      <= WIDTH'(RESET_VAL);
            Step_valid <= 1'b0;
            Step_dir   <= DIR_DOWN;
            Quad_err   <= 1'b0;
        end else begin
            Count      <= count_next;
            Step_valid <= !Load && (step_up || step_dn) && (count_next != Count);
            Quad_err   <= err;
            if (!Load && step_up)      Step_dir <= DIR_UP;
            else if (!Load && step_dn) Step_dir <= DIR_DOWN;
        end
    end

    assign At_min = (Count == WIDTH'(MIN_VAL));
    assign At_max = (Count == WIDTH'(MAX_VAL));

endmodule

// File: tb/tb_rotary_counter_core.sv
// Bench for rotary_counter_core: a saturating instance (11-bit so that an
// out-of-range load value fits the port) and a wrapping 0..9 instance.
// Detent completions push the expected count/direction; the monitor pops
// them when Step_valid fires.
module tb_rotary_counter_core;

    localparam int TD = 4;

    typedef struct {
        int cnt;
        bit dir;
    } exp_t;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;

    logic        a0 = 1'b1, b0 = 1'b1, load0 = 1'b0;
    logic [10:0] lv0 = '0;
    logic [10:0] cnt0;
    logic        sv0, sd0, qe0, amin0, amax0;

    logic        a1 = 1'b1, b1 = 1'b1, load1 = 1'b0;
    logic [3:0]  lv1 = '0;
    logic [3:0]  cnt1;
    logic        sv1, sd1, qe1, amin1, amax1;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   err0     = 0;
    int   m_cnt[2];
    int   m_min[2];
    int   m_max[2];
    bit   m_wrap[2];
    logic [1:0] ph[2];
    exp_t q0[$];
    exp_t q1[$];

    always #5 Clk = ~Clk;

    rotary_counter_core #(
        .WIDTH(11), .MIN_VAL(0), .MAX_VAL(1023), .RESET_VAL(0), .WRAP(0),
        .TICK_DIV(TD), .DEBOUNCE_TICKS(4), .STEPS_PER_DETENT(4),
        .ACCEL_WINDOW(30), .ACCEL_STEP(8)
    ) u_sat (
        .Clk(Clk), .Reset_n(Reset_n), .A_raw(a0), .B_raw(b0),
        .Load(load0), .Load_value(lv0), .Count(cnt0), .Step_valid(sv0),
        .Step_dir(sd0), .Quad_err(qe0), .At_min(amin0), .At_max(amax0)
    );

    rotary_counter_core #(
        .WIDTH(4), .MIN_VAL(0), .MAX_VAL(9), .RESET_VAL(0), .WRAP(1),
        .TICK_DIV(TD), .DEBOUNCE_TICKS(4), .STEPS_PER_DETENT(4),
        .ACCEL_WINDOW(30), .ACCEL_STEP(8)
    ) u_wrap (
        .Clk(Clk), .Reset_n(Reset_n), .A_raw(a1), .B_raw(b1),
        .Load(load1), .Load_value(lv1), .Count(cnt1), .Step_valid(sv1),
        .Step_dir(sd1), .Quad_err(qe1), .At_min(amin1), .At_max(amax1)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    endtask

    // Scoreboard side: every Step_valid must match a pending expected step
    always @(negedge Clk) begin
        if (Reset_n) begin
            if (qe0) err0++;
            if (sv0) begin
                chk("sat_step_pending", int'(q0.size() > 0), 1);
                if (q0.size() > 0) begin
                    exp_t e;
                    e = q0.pop_front();
                    chk("sat_step_count", int'(cnt0), e.cnt);
                    chk("sat_step_dir", int'(sd0), int'(e.dir));
                end
            end
            if (sv1) begin
                chk("wrap_step_pending", int'(q1.size() > 0), 1);
                if (q1.size() > 0) begin
                    exp_t e;
                    e = q1.pop_front();
                    chk("wrap_step_count", int'(cnt1), e.cnt);
                    chk("wrap_step_dir", int'(sd1), int'(e.dir));
                end
            end
        end
    end

    function automatic logic [1:0] next_ph(input logic [1:0] p, input bit up);
        logic [1:0] n;
        case (p)
            2'b00:   n = up ? 2'b10 : 2'b01;
            2'b10:   n = up ? 2'b11 : 2'b00;
            2'b11:   n = up ? 2'b01 : 2'b10;
            default: n = up ? 2'b00 : 2'b11;
        endcase
        return n;
    endfunction

    task automatic drive_ph(input int sel, input logic [1:0] p, input int hold);
        @(negedge Clk);
        ph[sel] = p;
        if (sel == 0) begin a0 = ~p[1]; b0 = ~p[0]; end
        else          begin a1 = ~p[1]; b1 = ~p[0]; end
        repeat (hold * TD) @(negedge Clk);
    endtask

    task automatic move(input int sel, input bit up, input int hold);
        drive_ph(sel, next_ph(ph[sel], up), hold);
    endtask

    task automatic expect_step(input int sel, input bit up, input int inc);
        int   n;
        exp_t e;
        n = up ? m_cnt[sel] + inc : m_cnt[sel] - inc;
        if (n > m_max[sel]) n = m_wrap[sel] ? m_min[sel] : m_max[sel];
        if (n < m_min[sel]) n = m_wrap[sel] ? m_max[sel] : m_min[sel];
        if (n != m_cnt[sel]) begin
            e.cnt = n;
            e.dir = up;
            if (sel == 0) q0.push_back(e);
            else          q1.push_back(e);
        end
        m_cnt[sel] = n;
    endtask

    task automatic detent(input int sel, input bit up, input int hold, input int inc);
        repeat (3) move(sel, up, hold);
        expect_step(sel, up, inc);
        move(sel, up, hold);
    endtask

    task automatic do_load(input int sel, input int v);
        @(negedge Clk);
        if (sel == 0) begin load0 = 1'b1; lv0 = 11'(v); end
        else          begin load1 = 1'b1; lv1 = 4'(v);  end
        @(negedge Clk);
        load0 = 1'b0;
        load1 = 1'b0;
        m_cnt[sel] = (v > m_max[sel]) ? m_max[sel] : (v < m_min[sel]) ? m_min[sel] : v;
        @(negedge Clk);
    endtask

    initial begin
        m_cnt[0] = 0; m_min[0] = 0; m_max[0] = 1023; m_wrap[0] = 1'b0;
        m_cnt[1] = 0; m_min[1] = 0; m_max[1] = 9;    m_wrap[1] = 1'b1;
        ph[0] = 2'b00; ph[1] = 2'b00;
        repeat (5) @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);

        // Reset state
        chk("rst_count", int'(cnt0), 0);
        chk("rst_step_valid", int'(sv0), 0);
        chk("rst_step_dir", int'(sd0), 0);
        chk("rst_quad_err", int'(qe0), 0);
        chk("rst_at_min", int'(amin0), 1);
        chk("rst_at_max", int'(amax0), 0);
        chk("rst_wrap_count", int'(cnt1), 0);

        // One clean CW detent
        detent(0, 1'b1, 8, 1);
        chk("cw_count", int'(cnt0), m_cnt[0]);
        chk("cw_dir", int'(sd0), 1);
        chk("cw_at_min", int'(amin0), 0);
        chk("cw_drained", q0.size(), 0);

        // Partial detent reversed: nothing counted
        repeat (3) move(0, 1'b1, 8);
        repeat (3) move(0, 1'b0, 8);
        chk("back_forth_count", int'(cnt0), m_cnt[0]);

        // Three CCW transitions, a short A glitch, then the completing transition
        repeat (3) move(0, 1'b0, 8);
        @(negedge Clk);
        a0 = 1'b1;
        repeat (3 * TD - 1) @(negedge Clk);
        a0 = 1'b0;
        repeat (8 * TD) @(negedge Clk);
        chk("glitch_no_step", int'(cnt0), m_cnt[0]);
        expect_step(0, 1'b0, 1);
        move(0, 1'b0, 8);
        chk("ccw_count", int'(cnt0), m_cnt[0]);
        chk("ccw_dir", int'(sd0), 0);
        chk("ccw_drained", q0.size(), 0);

        // CCW detent at the lower bound saturates silently
        detent(0, 1'b0, 8, 1);
        chk("sat_min_count", int'(cnt0), 0);
        chk("sat_min_dir", int'(sd0), 0);
        chk("sat_min_at_min", int'(amin0), 1);

        // Illegal two-bit moves clear the accumulator
        move(0, 1'b1, 8);
        drive_ph(0, 2'b01, 8);
        move(0, 1'b1, 8);
        move(0, 1'b1, 8);
        move(0, 1'b1, 8);
        expect_step(0, 1'b1, 1);
        move(0, 1'b1, 8);
        repeat (3) move(0, 1'b1, 8);
        drive_ph(0, 2'b00, 8);
        chk("quad_err_pulses", err0, 2);
        chk("quad_err_count", int'(cnt0), m_cnt[0]);
        chk("quad_err_drained", q0.size(), 0);

        // Clamped load, then a saturated CW step still flips Step_dir
        detent(0, 1'b0, 8, 1);
        do_load(0, 2000);
        chk("load_clamp_count", int'(cnt0), 1023);
        chk("load_clamp_at_max", int'(amax0), 1);
        chk("load_keeps_dir", int'(sd0), 0);
        detent(0, 1'b1, 8, 1);
        chk("sat_max_count", int'(cnt0), 1023);
        chk("sat_max_dir", int'(sd0), 1);
        chk("sat_max_drained", q0.size(), 0);

        // Load held across a completing up step: step dropped
        detent(0, 1'b0, 8, 1);
        chk("pre_load_count", int'(cnt0), 1022);
        repeat (3) move(0, 1'b1, 8);
        @(negedge Clk);
        load0 = 1'b1;
        lv0   = 11'd2000;
        move(0, 1'b1, 8);
        load0 = 1'b0;
        m_cnt[0] = 1023;
        @(negedge Clk);
        chk("load_vs_step_count", int'(cnt0), 1023);
        chk("load_vs_step_drained", q0.size(), 0);

        // Reset in the middle of a detent discards the partial progress
        repeat (3) move(0, 1'b1, 8);
        @(negedge Clk);
        Reset_n = 1'b0;
        a0 = 1'b1; b0 = 1'b1; ph[0] = 2'b00;
        #1;
        chk("async_rst_count", int'(cnt0), 0);
        repeat (4) @(negedge Clk);
        Reset_n = 1'b1;
        m_cnt[0] = 0;
        m_cnt[1] = 0;
        @(negedge Clk);
        chk("post_rst_dir", int'(sd0), 0);
        detent(0, 1'b1, 8, 1);
        chk("post_rst_count", int'(cnt0), 1);
        chk("post_rst_drained", q0.size(), 0);

        // Wrapping instance across MAX_VAL and back
        do_load(1, 9);
        chk("wrap_load", int'(cnt1), 9);
        chk("wrap_at_max", int'(amax1), 1);
        detent(1, 1'b1, 8, 1);
        chk("wrap_up_count", int'(cnt1), 0);
        chk("wrap_up_at_min", int'(amin1), 1);
        detent(1, 1'b0, 8, 1);
        chk("wrap_down_count", int'(cnt1), 9);
        chk("wrap_down_dir", int'(sd1), 0);
        chk("wrap_drained", q1.size(), 0);

`ifdef ROTARY_ACCEL_EN
        // Acceleration: quick same-direction detents step by ACCEL_STEP
        do_load(0, 100);
        repeat (40 * TD) @(negedge Clk);
        detent(0, 1'b1, 6, 1);
        chk("accel_first", int'(cnt0), 101);
        detent(0, 1'b1, 6, 8);
        chk("accel_fast", int'(cnt0), 109);
        repeat (40 * TD) @(negedge Clk);
        detent(0, 1'b1, 6, 1);
        chk("accel_slow", int'(cnt0), 110);
        chk("accel_drained", q0.size(), 0);
`endif

        repeat (4) @(negedge Clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
